// File: rtl/s2p_pkg.sv
// Shared types for the serial-to-parallel word assembler.
package s2p_pkg;
  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_PARITY = 2'd1,
    S_HOLD   = 2'd2
  } s2p_state_t;
endpackage

// File: rtl/decoder_n.sv
// Index to one-hot write-enable decoder; the structural inverse of an N:1 bit-select mux.
module decoder_n #(
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     we
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    we = ONE << idx;
  end
endmodule

// File: rtl/serial_to_parallel_n.sv
// Rebuilds an N-bit word from an LSB-first bit stream behind a valid/ready output port.
// Optional trailing even-parity bit enabled by defining S2P_PARITY_EN.
module serial_to_parallel_n
  import s2p_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_word,
  input  logic             out_ready,
  output logic [IDX_W-1:0] bit_idx,
  output logic             out_parity_err
);
  s2p_state_t       state, state_nxt;
  logic [N-1:0]     we;
  logic             accept;
  logic             last_bit;

  decoder_n #(.N(N), .IDX_W(IDX_W)) u_dec (
    .idx (bit_idx),
    .we  (we)
  );

  assign in_ready  = (state == S_FILL) || (state == S_PARITY);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (bit_idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (accept && last_bit) begin
`ifdef S2P_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_HOLD;
`endif
        end
      end
      S_PARITY: if (accept) state_nxt = S_HOLD;
      S_HOLD:   if (out_ready) state_nxt = S_FILL;
      default:  state_nxt = S_FILL;
    endcase
  end

  // Index wraps only on the last data bit, so it never reaches N even for non-power-of-2 N.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx  <= '0;
      out_word <= '0;
    end else if (state == S_FILL && accept) begin
      out_word <= (out_word & ~we) | ({N{in_bit}} & we);
      bit_idx  <= last_bit ? '0 : bit_idx + 1'b1;
    end
  end

`ifdef S2P_PARITY_EN
  logic parity_err;

  always_ff @(posedge clk) begin
    if (rst)                              parity_err <= 1'b0;
    else if (state == S_PARITY && accept) parity_err <= in_bit ^ (^out_word);
  end

  assign out_parity_err = parity_err;
`else
  assign out_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_to_parallel_n.sv
// Randomized self-checking bench for serial_to_parallel_n against a word-level reference model.
module tb_serial_to_parallel_n;
  import s2p_pkg::*;

  localparam int N     = 32;
  localparam int IDX_W = $clog2(N);
`ifdef S2P_PARITY_EN
  localparam int NBITS = N + 1;
`else
  localparam int NBITS = N;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic [N-1:0]     out_word;
  logic             out_ready;
  logic [IDX_W-1:0] bit_idx;
  logic             out_parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  serial_to_parallel_n #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_word       (out_word),
    .out_ready      (out_ready),
    .bit_idx        (bit_idx),
    .out_parity_err (out_parity_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter side: an N:1 mux whose select is the bit counter.
  function automatic logic mux_sel(input logic [N-1:0] w, input int sel);
    logic [N-1:0] t;
    t = w >> sel;
    return t[0];
  endfunction

  function automatic logic model_parity_err(input logic [N-1:0] w, input logic p);
`ifdef S2P_PARITY_EN
    return logic'(($countones(w) + int'(p)) % 2);
`else
    return 1'b0;
`endif
  endfunction

  // Sends one word (plus parity bit p when enabled) with random in_valid gaps,
  // then holds out_ready low for `hold` cycles before taking the word.
  task automatic send_word(input logic [N-1:0] w, input logic p, input int gap_pct,
                           input int hold, input string tag);
    int  cyc;
    int  guard;
    logic acc;
    cyc = 0;
    out_ready = (hold == 0);
    for (int k = 0; k < NBITS; k++) begin
      guard = 0;
      forever begin
        in_bit   = (k < N) ? mux_sel(w, k) : p;
        in_valid = (int'($urandom_range(99)) >= gap_pct);
        check_eq({tag, "_in_ready_fill"}, in_ready, 1'b1);
        check_eq({tag, "_out_valid_fill"}, out_valid, 1'b0);
        if (k < N) check_eq({tag, "_bit_idx"}, bit_idx, k);
        acc = in_valid;
        tick();
        cyc++;
        if (acc) break;
        guard++;
        if (guard > 200) begin
          check_eq({tag, "_accept_timeout"}, guard, 0);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    if (gap_pct == 0) check_eq({tag, "_latency"}, cyc, NBITS);
    check_eq({tag, "_out_valid"}, out_valid, 1'b1);
    check_eq({tag, "_out_word"}, out_word, w);
    check_eq({tag, "_parity_err"}, out_parity_err, model_parity_err(w, p));
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq({tag, "_hold_in_ready"}, in_ready, 1'b0);
      check_eq({tag, "_hold_out_valid"}, out_valid, 1'b1);
      check_eq({tag, "_hold_word"}, out_word, w);
    end
    out_ready = 1'b1;
    check_eq({tag, "_take_in_ready"}, in_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_after_take_valid"}, out_valid, 1'b0);
    check_eq({tag, "_after_take_idx"}, bit_idx, 0);
    check_eq({tag, "_after_take_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [N-1:0] w;
    logic         p;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_word", out_word, 0);
    check_eq("rst_bit_idx", bit_idx, 0);
    check_eq("rst_parity_err", out_parity_err, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);

    // Idle cycles must not move the index.
    for (int i = 0; i < 4; i++) tick();
    check_eq("idle_bit_idx", bit_idx, 0);

    send_word(32'hDEADBEEF, 1'b0, 0, 0, "deadbeef");
    send_word(32'h0000_0001, 1'b1, 0, 5, "hold5");

    // Abort a word of ones mid-stream; reset wins over a simultaneous valid bit.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      tick();
    end
    check_eq("partial_idx", bit_idx, 10);
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("abort_bit_idx", bit_idx, 0);
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_out_word", out_word, 0);
    send_word(32'h1234_5678, 1'b1, 0, 0, "after_abort");

    send_word(32'hA5A5_0F0F, 1'b0, 50, 0, "gaps");

`ifdef S2P_PARITY_EN
    send_word(32'h0000_0003, 1'b1, 0, 0, "par_p1");
    check_eq("par_p1_flag_seen", model_parity_err(32'h0000_0003, 1'b1), 1'b1);
    send_word(32'h0000_0003, 1'b0, 0, 0, "par_p0");
`endif

    for (int i = 0; i < 300; i++) begin
      w = N'($urandom());
      p = 1'($urandom_range(1));
      send_word(w, p, int'($urandom_range(60)), int'($urandom_range(3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
